// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared ALU control encoding and decode constants for exec_mem_stage
package exec_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_MUL  = 4'd10
  } alu_ctrl_e;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

endpackage

// File: rtl/exec_alu_decode.sv
// rtl/exec_alu_decode.sv - alu_op/funct3/funct7 to ALU control decode (MUL gated by ALU_MUL_EN)
module exec_alu_decode
  import exec_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  output alu_ctrl_e  o_alu_ctrl
);

  // Map the instruction class and function fields onto one ALU operation
  always_comb begin
    o_alu_ctrl = ALU_ADD;
    case (i_alu_op)
      ALUOP_MEM: o_alu_ctrl = ALU_ADD;
      ALUOP_BR:  o_alu_ctrl = ALU_SUB;
      default: begin
        // R-type and I-type share the funct3 table; only R-type honours SUB
        case (i_funct3)
          3'b000: o_alu_ctrl = (i_alu_op == ALUOP_R && i_funct7 == FUNCT7_ALT) ? ALU_SUB : ALU_ADD;
          3'b001: o_alu_ctrl = ALU_SLL;
          3'b010: o_alu_ctrl = ALU_SLT;
          3'b011: o_alu_ctrl = ALU_SLTU;
          3'b100: o_alu_ctrl = ALU_XOR;
          3'b101: o_alu_ctrl = i_funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110: o_alu_ctrl = ALU_OR;
          default: o_alu_ctrl = ALU_AND;
        endcase
`ifdef ALU_MUL_EN
        // The M-extension funct7 only yields MUL for funct3 000; the rest fall back to ADD
        if (i_alu_op == ALUOP_R && i_funct7 == FUNCT7_MULDIV) begin
          o_alu_ctrl = (i_funct3 == 3'b000) ? ALU_MUL : ALU_ADD;
        end
`endif
      end
    endcase
  end

endmodule

// File: rtl/exec_mem_stage.sv
// rtl/exec_mem_stage.sv - RV64 execute/memory stage: ALU, word data memory, write-back mux (ALU_MUL_EN adds MUL)
module exec_mem_stage
  import exec_pkg::*;
#(
  parameter int WORDSIZE = 64,
  parameter int DM_DEPTH = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WORDSIZE-1:0] rs1_data,
  input  logic [WORDSIZE-1:0] rs2_data,
  input  logic [WORDSIZE-1:0] imm,
  input  logic                alu_src,
  input  logic [1:0]          alu_op,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic                dm_write_en,
  input  logic                mem_to_reg,
  output logic [WORDSIZE-1:0] alu_result,
  output logic                zero,
  output logic [WORDSIZE-1:0] mem_rdata,
  output logic [WORDSIZE-1:0] wb_data
);

  localparam int AW = $clog2(DM_DEPTH);

  alu_ctrl_e           w_alu_ctrl;
  logic [WORDSIZE-1:0] w_a;
  logic [WORDSIZE-1:0] w_b;
  logic [5:0]          w_shamt;
  logic                w_lt_s;
  logic                w_lt_u;
  logic [WORDSIZE-1:0] w_alu_result;
  logic [AW-1:0]       w_index;
  logic [WORDSIZE-1:0] r_mem [DM_DEPTH];

  exec_alu_decode u_decode (
    .i_alu_op   (alu_op),
    .i_funct3   (funct3),
    .i_funct7   (funct7),
    .o_alu_ctrl (w_alu_ctrl)
  );

  assign w_a     = rs1_data;
  assign w_b     = alu_src ? imm : rs2_data;
  assign w_shamt = w_b[5:0];
  assign w_lt_s  = $signed(w_a) < $signed(w_b);
  assign w_lt_u  = w_a < w_b;

  // Compute the ALU result for the decoded operation
  always_comb begin
    w_alu_result = w_a + w_b;
    case (w_alu_ctrl)
      ALU_SUB:  w_alu_result = w_a - w_b;
      ALU_AND:  w_alu_result = w_a & w_b;
      ALU_OR:   w_alu_result = w_a | w_b;
      ALU_XOR:  w_alu_result = w_a ^ w_b;
      ALU_SLL:  w_alu_result = w_a << w_shamt;
      ALU_SRL:  w_alu_result = w_a >> w_shamt;
      ALU_SRA:  w_alu_result = $unsigned($signed(w_a) >>> w_shamt);
      ALU_SLT:  w_alu_result = {{(WORDSIZE-1){1'b0}}, w_lt_s};
      ALU_SLTU: w_alu_result = {{(WORDSIZE-1){1'b0}}, w_lt_u};
`ifdef ALU_MUL_EN
      ALU_MUL:  w_alu_result = w_a * w_b;
`endif
      default:  w_alu_result = w_a + w_b;
    endcase
  end

  // Byte offset bits and bits above the memory size are dropped, so addresses wrap
  assign w_index = w_alu_result[AW+2:3];

  // Word-wide store; reset clears every word and blocks any write in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DM_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (dm_write_en) begin
      r_mem[w_index] <= rs2_data;
    end
  end

  assign alu_result = w_alu_result;
  assign zero       = ~|w_alu_result;
  assign mem_rdata  = r_mem[w_index];
  assign wb_data    = mem_to_reg ? r_mem[w_index] : w_alu_result;

endmodule

// File: tb/tb_exec_mem_stage.sv
// tb/tb_exec_mem_stage.sv - scoreboard bench for exec_mem_stage (expects MUL result when ALU_MUL_EN is defined)
module tb_exec_mem_stage;

  logic        clk;
  logic        rst_n;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic [63:0] imm;
  logic        alu_src;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        dm_write_en;
  logic        mem_to_reg;
  logic [63:0] alu_result;
  logic        zero;
  logic [63:0] mem_rdata;
  logic [63:0] wb_data;

  localparam logic [3:0] M_ALU = 4'b0001;
  localparam logic [3:0] M_Z   = 4'b0010;
  localparam logic [3:0] M_RD  = 4'b0100;
  localparam logic [3:0] M_WB  = 4'b1000;

  typedef struct {
    logic [127:0] name;
    logic [3:0]   mask;
    logic [63:0]  e_alu;
    logic         e_z;
    logic [63:0]  e_rd;
    logic [63:0]  e_wb;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run;
  int   tests_failed;

  exec_mem_stage #(.WORDSIZE(64), .DM_DEPTH(256)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .imm         (imm),
    .alu_src     (alu_src),
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7      (funct7),
    .dm_write_en (dm_write_en),
    .mem_to_reg  (mem_to_reg),
    .alu_result  (alu_result),
    .zero        (zero),
    .mem_rdata   (mem_rdata),
    .wb_data     (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input logic [127:0] nm, input logic [127:0] fld,
                     input logic [63:0] act, input logic [63:0] exp_v);
    tests_run++;
    if (act !== exp_v) begin
      tests_failed++;
      $display("FAIL %0s.%0s: got 0x%016h expected 0x%016h", nm, fld, act, exp_v);
    end
  endtask

  // Monitor: outputs are settled by the falling edge, so compare one entry there
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.mask[0]) chk(e.name, "alu", alu_result, e.e_alu);
      if (e.mask[1]) chk(e.name, "zero", {63'b0, zero}, {63'b0, e.e_z});
      if (e.mask[2]) chk(e.name, "rdata", mem_rdata, e.e_rd);
      if (e.mask[3]) chk(e.name, "wb", wb_data, e.e_wb);
    end
  end

  task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic [63:0] im,
                       input logic src, input logic [1:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic we, input logic m2r);
    rs1_data    = a;
    rs2_data    = b;
    imm         = im;
    alu_src     = src;
    alu_op      = op;
    funct3      = f3;
    funct7      = f7;
    dm_write_en = we;
    mem_to_reg  = m2r;
  endtask

  task automatic expect_v(input logic [127:0] nm, input logic [3:0] mask, input logic [63:0] ea,
                          input logic ez, input logic [63:0] erd, input logic [63:0] ewb);
    exp_t e;
    e.name = nm; e.mask = mask; e.e_alu = ea; e.e_z = ez; e.e_rd = erd; e.e_wb = ewb;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Read helper: address = rs1 + imm through the load/store ADD path
  task automatic rd(input logic [127:0] nm, input logic [63:0] addr, input logic [63:0] e_rd);
    drive(addr, 64'h0, 64'h0, 1'b1, 2'b00, 3'b011, 7'h00, 1'b0, 1'b1);
    expect_v(nm, M_ALU | M_RD | M_WB, addr, 1'b0, e_rd, e_rd);
    step();
  endtask

  localparam logic [63:0] STORE_V = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] WRAP_V  = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] MIN64   = 64'h8000_0000_0000_0000;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    drive(64'h0, 64'h0, 64'h0, 1'b0, 2'b00, 3'b000, 7'h00, 1'b0, 1'b0);
    step();

    // During reset: ALU follows inputs, memory reads 0, and a write is ignored
    drive(64'h8, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0, 1'b1, 2'b00, 3'b011, 7'h00, 1'b1, 1'b0);
    expect_v("rst_live", M_ALU | M_RD, 64'h8, 1'b0, 64'h0, 64'h0);
    step();
    dm_write_en = 1'b0;
    rst_n       = 1'b1;
    step();
    rd("rst_a0", 64'h0, 64'h0);
    rd("rst_a8", 64'h8, 64'h0);
    rd("rst_a7f8", 64'h7F8, 64'h0);

    // R-type arithmetic
    drive(64'd5, 64'd7, 64'h0, 1'b0, 2'b10, 3'b000, 7'b0000000, 1'b0, 1'b0);
    expect_v("r_add", M_ALU | M_Z | M_WB, 64'd12, 1'b0, 64'h0, 64'd12);
    step();
    drive(64'd5, 64'd7, 64'h0, 1'b0, 2'b10, 3'b000, 7'b0100000, 1'b0, 1'b0);
    expect_v("r_sub", M_ALU | M_Z, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 64'h0, 64'h0);
    step();
    drive(64'd9, 64'd9, 64'h0, 1'b0, 2'b10, 3'b000, 7'b0100000, 1'b0, 1'b0);
    expect_v("r_sub0", M_ALU | M_Z, 64'h0, 1'b1, 64'h0, 64'h0);
    step();
    drive(64'h55, 64'h55, 64'h0, 1'b0, 2'b01, 3'b000, 7'h00, 1'b0, 1'b0);
    expect_v("br_eq", M_ALU | M_Z, 64'h0, 1'b1, 64'h0, 64'h0);
    step();
    drive(64'd10, 64'd99, 64'd3, 1'b1, 2'b11, 3'b000, 7'b0100000, 1'b0, 1'b0);
    expect_v("addi", M_ALU | M_Z, 64'd13, 1'b0, 64'h0, 64'h0);
    step();

    // Logic ops
    drive(64'hF0F0, 64'h0FF0, 64'h0, 1'b0, 2'b10, 3'b100, 7'h00, 1'b0, 1'b0);
    expect_v("xor", M_ALU, 64'hFF00, 1'b0, 64'h0, 64'h0);
    step();
    drive(64'hF0F0, 64'h0FF0, 64'h0, 1'b0, 2'b10, 3'b110, 7'h00, 1'b0, 1'b0);
    expect_v("or", M_ALU, 64'hFFF0, 1'b0, 64'h0, 64'h0);
    step();
    drive(64'hF0F0, 64'h0FF0, 64'h0, 1'b0, 2'b10, 3'b111, 7'h00, 1'b0, 1'b0);
    expect_v("and", M_ALU, 64'h00F0, 1'b0, 64'h0, 64'h0);
    step();

    // Shifts and compares
    drive(MIN64, 64'h0, 64'd4, 1'b1, 2'b11, 3'b101, 7'b0100000, 1'b0, 1'b0);
    expect_v("srai", M_ALU, 64'hF800_0000_0000_0000, 1'b0, 64'h0, 64'h0);
    step();
    drive(MIN64, 64'h0, 64'd4, 1'b1, 2'b11, 3'b101, 7'b0000000, 1'b0, 1'b0);
    expect_v("srli", M_ALU, 64'h0800_0000_0000_0000, 1'b0, 64'h0, 64'h0);
    step();
    drive(MIN64, 64'h0, 64'h44, 1'b1, 2'b11, 3'b101, 7'b0000000, 1'b0, 1'b0);
    expect_v("srl_shamt6", M_ALU, 64'h0800_0000_0000_0000, 1'b0, 64'h0, 64'h0);
    step();
    drive(64'd1, 64'h0, 64'd63, 1'b1, 2'b11, 3'b001, 7'h00, 1'b0, 1'b0);
    expect_v("slli63", M_ALU, MIN64, 1'b0, 64'h0, 64'h0);
    step();
    drive(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h0, 1'b0, 2'b10, 3'b010, 7'h00, 1'b0, 1'b0);
    expect_v("slt", M_ALU | M_Z, 64'd1, 1'b0, 64'h0, 64'h0);
    step();
    drive(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h0, 1'b0, 2'b10, 3'b011, 7'h00, 1'b0, 1'b0);
    expect_v("sltu", M_ALU | M_Z, 64'd0, 1'b1, 64'h0, 64'h0);
    step();

    // Store then load: old data before the edge, new data after it
    drive(64'h10, STORE_V, 64'd8, 1'b1, 2'b00, 3'b011, 7'h00, 1'b1, 1'b0);
    expect_v("st_pre", M_ALU | M_RD | M_WB, 64'h18, 1'b0, 64'h0, 64'h18);
    step();
    drive(64'h10, STORE_V, 64'd8, 1'b1, 2'b00, 3'b011, 7'h00, 1'b0, 1'b1);
    expect_v("st_post", M_ALU | M_RD | M_WB, 64'h18, 1'b0, STORE_V, STORE_V);
    step();
    drive(64'h13, 64'h0, 64'd8, 1'b1, 2'b00, 3'b011, 7'h00, 1'b0, 1'b0);
    expect_v("ld_1b", M_ALU | M_RD | M_WB, 64'h1B, 1'b0, STORE_V, 64'h1B);
    step();

    // Address wrap: 0x800 aliases word 0
    drive(64'h800, WRAP_V, 64'h0, 1'b1, 2'b00, 3'b011, 7'h00, 1'b1, 1'b0);
    expect_v("wr_800", M_ALU | M_RD, 64'h800, 1'b0, 64'h0, 64'h0);
    step();
    rd("wrap_a0", 64'h0, WRAP_V);
    rd("keep_a18", 64'h18, STORE_V);

    // MUL slot
    drive(64'd6, 64'd7, 64'h0, 1'b0, 2'b10, 3'b000, 7'b0000001, 1'b0, 1'b0);
`ifdef ALU_MUL_EN
    expect_v("mul", M_ALU, 64'd42, 1'b0, 64'h0, 64'h0);
`else
    expect_v("mul_off", M_ALU, 64'd13, 1'b0, 64'h0, 64'h0);
`endif
    step();
    drive(64'd6, 64'd7, 64'h0, 1'b0, 2'b10, 3'b100, 7'b0000001, 1'b0, 1'b0);
`ifdef ALU_MUL_EN
    expect_v("m_f3_100", M_ALU, 64'd13, 1'b0, 64'h0, 64'h0);
`else
    expect_v("m_f3_100", M_ALU, 64'd1, 1'b0, 64'h0, 64'h0);
`endif
    step();

    // Asynchronous reset mid-cycle clears memory and discards the pending write
    drive(64'h18, 64'h77, 64'h0, 1'b1, 2'b00, 3'b011, 7'h00, 1'b1, 1'b1);
    rst_n = 1'b0;
    expect_v("arst_clr", M_ALU | M_RD | M_WB, 64'h18, 1'b0, 64'h0, 64'h0);
    step();
    dm_write_en = 1'b0;
    rst_n       = 1'b1;
    step();
    rd("arst_a18", 64'h18, 64'h0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/exec_mem_stage.md
Name: exec_mem_stage

Overview:
- Execute/memory stage of the single-cycle RV64 datapath.
- Decodes ALU control from alu_op/funct3/funct7, selects operand B (register or immediate), and computes the 64-bit ALU result and zero flag.
- Uses the result to address a word-organised data memory, and produces the write-back value (memory data or ALU result).

Parameters:
- WORDSIZE, 64, datapath and memory word width in bits.
- DM_DEPTH, 256, number of WORDSIZE-bit words in data memory; must be a power of 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rs1_data  in  WORDSIZE  operand A.
- rs2_data  in  WORDSIZE  register operand B; also the store data.
- imm  in  WORDSIZE  sign-extended immediate.
- alu_src  in  1  1 selects imm as operand B; 0 selects rs2_data.
- alu_op  in  2  class code: 00 load/store, 01 branch, 10 R-type, 11 I-type ALU.
- funct3  in  3  instruction funct3.
- funct7  in  7  instruction funct7.
- dm_write_en  in  1  store enable.
- mem_to_reg  in  1  1 selects memory data for write-back.
- alu_result  out  WORDSIZE  ALU output.
- zero  out  1  1 when alu_result == 0.
- mem_rdata  out  WORDSIZE  data memory read value.
- wb_data  out  WORDSIZE  write-back value.

Behaviour:
- All outputs are combinational from inputs and memory state.
- Only the memory is clocked.

ALU control decode:
- alu_op 00 selects ADD.
- alu_op 01 selects SUB.
- alu_op 10 decodes on funct3:
  - 000: SUB if funct7 == 0100000, else ADD.
  - 001: SLL.
  - 010: SLT.
  - 011: SLTU.
  - 100: XOR.
  - 101: SRA if funct7[5], else SRL.
  - 110: OR.
  - 111: AND.
- alu_op 11 decodes the same way, except funct3 000 is always ADD (ADDI).

ALU operations:
- B = alu_src ? imm : rs2_data.
- ADD and SUB wrap modulo 2^WORDSIZE; no flags other than zero.
- Shift amount is B[5:0]; SRA replicates A[63].
- SLT is a signed compare, SLTU an unsigned compare; the result is 1 or 0, zero-extended.
- zero = ~|alu_result. Branch equality uses SUB.

Data memory:
- DM_DEPTH words, byte-addressed by alu_result.
- Word index = alu_result[$clog2(DM_DEPTH)+2:3].
- alu_result[2:0] is ignored, so no misaligned access or traps.
- Higher address bits are ignored, so addresses wrap modulo DM_DEPTH*8.
- Read is asynchronous: mem_rdata = mem[index] at all times.
- Write: on the rising clk edge with dm_write_en=1 and rst_n=1, mem[index] <= rs2_data as a full word.
- Read during a write to the same index returns the old data until the edge, and the new data immediately after it.

Reset:
- rst_n low asynchronously clears every memory word to 0; writes are ignored while low.
- After reset, mem_rdata = 0 for every address.
- alu_result, zero and wb_data still follow their inputs during reset.
- Reset asserted mid-cycle discards a pending write.

Write-back:
- wb_data = mem_to_reg ? mem_rdata : alu_result.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined: alu_op 10 with funct7 == 0000001 and funct3 000 selects MUL, giving the low WORDSIZE bits of the unsigned/signed-agnostic product rs1_data*B. Other funct3 values with funct7 0000001 decode as ADD.
- Not defined: funct7 0000001 decodes exactly as funct7 0000000, i.e. ADD for funct3 000. No multiplier is synthesised.

Decomposition:
- Shared package exec_pkg holds:
  - enum alu_ctrl_e (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, MUL), 4 bits.
  - Constants ALUOP_MEM=2'b00, ALUOP_BR=2'b01, ALUOP_R=2'b10, ALUOP_I=2'b11.
  - Constant FUNCT7_ALT=7'b0100000.
- One sub-module, exec_alu_decode: combinational alu_op/funct3/funct7 to alu_ctrl_e.
- The ALU datapath and memory stay inline in exec_mem_stage.

Test Plan:
- Reset: assert rst_n=0, then release; read addresses 0x0, 0x8 and 0x7F8 -> mem_rdata = 0; writes pulsed during reset -> no effect.
- R-type arithmetic: rs1=5, rs2=7, alu_op=10:
  - funct3 000 / funct7 0000000 -> 12.
  - funct7 0100000 -> 0xFFFF_FFFF_FFFF_FFFE, zero=0.
  - rs1=rs2=9 with SUB -> 0, zero=1.
- Shifts and compares: rs1=0x8000_0000_0000_0000, imm=4, alu_src=1, alu_op=11:
  - funct3 101 / funct7 0100000 -> 0xF800_0000_0000_0000.
  - funct7 0 -> 0x0800_0000_0000_0000.
  - SLT with rs1=-1, rs2=1 -> 1; SLTU -> 0.
- Store/load: alu_op=00, rs1=0x10, imm=8, rs2=0xDEAD_BEEF_0123_4567, dm_write_en=1 for one edge.
  - mem_rdata before the edge is old (0); after the edge it is the stored value.
  - mem_to_reg=1 -> wb_data = stored value.
  - Address 0x1B (same word) reads identically.
- Address wrap: store to 0x800 with DM_DEPTH=256 -> readable at address 0x0.
- ALU_MUL_EN: funct7 0000001, funct3 000, rs1=6, rs2=7:
  - Macro defined -> 42.
  - Macro undefined -> 13.
